piso_serializer: RTL and testbench
==================================

// Module: piso_serializer
// PURPOSE
//  Parallel-in/serial-out transmitter: the sending end of our serial bit link.
//  - Accepts a WIDTH-bit word over a valid/ready handshake.
//  - Drives the word out one bit per clk, with a bit-valid strobe and a last-bit marker.
//  - MSB-first by default, so a downstream 4-bit left-shifting deserializer
//    (shift in at LSB) reassembles the word unchanged after WIDTH bits.
//  - Supports seamless back-to-back words with no idle bubble.
// PARAMETERS
//  WIDTH      4   word width in bits (>=2)
//  MSB_FIRST  1   1: transmit data_i[WIDTH-1] first; 0: transmit data_i[0] first
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  data_i     in   WIDTH  parallel word to send
//  valid_i    in   1      data_i valid; transfer occurs when valid_i && ready_o at posedge clk
//  ready_o    out  1      serializer can accept a word this cycle
//  x_o        out  1      serial data bit
//  x_valid_o  out  1      x_o carries a valid bit this cycle
//  last_o     out  1      x_o is the final bit of the current word
//  busy_o     out  1      a word is being shifted out
// BEHAVIOUR
//  Reset
//  - While reset is high: state=IDLE, bit count=0, shift register=0.
//  - x_o=0, x_valid_o=0, last_o=0, busy_o=0.
//  - ready_o=1 once reset deasserts; any handshake seen while reset is high is ignored.
//  State machine
//  - Two states, IDLE and SHIFT, plus a bit counter cnt in 0..WIDTH-1.
//  - IDLE:
//    - ready_o=1, x_valid_o=0.
//    - On valid_i && ready_o: load shift register from data_i, set cnt=0, go to SHIFT.
//  - SHIFT:
//    - x_valid_o=1 and busy_o=1.
//    - Each clk: cnt increments and the shift register moves one bit toward the output end.
//    - x_o = reg[WIDTH-1] when MSB_FIRST=1, reg[0] when MSB_FIRST=0.
//    - last_o = (cnt==WIDTH-1).
//  ready_o and back-to-back words
//  - ready_o = IDLE || (SHIFT && cnt==WIDTH-1); combinational from state/cnt only.
//  - ready_o never depends on valid_i.
//  - In the last-bit cycle, if valid_i=1: the new word is loaded, cnt=0, state stays SHIFT.
//    Its first bit appears the very next cycle (no gap).
//  - In the last-bit cycle, if valid_i=0: go to IDLE; x_valid_o drops the next cycle.
//  Timing and data rules
//  - Latency: acceptance at edge N puts the first bit on x_o in cycle N+1.
//    The last bit is in cycle N+WIDTH.
//  - x_o, x_valid_o and last_o are registered (they change only on clk or reset).
//  - data_i is sampled only at the accepting edge. Later changes to data_i have no effect.
//  - Vacated shift positions fill with 0. x_o=0 whenever x_valid_o=0.
//  - A word is never truncated or repeated.
//  - Reset mid-word aborts the word immediately; no further bits of it are sent.
// TESTING
//  Defaults are WIDTH=4, MSB_FIRST=1 unless a line says otherwise.
//  1 Single word:
//    - Stimulus: data_i=4'b1011 accepted in cycle 0.
//    - Response: x_o=1,0,1,1 in cycles 1-4 with x_valid_o=1; last_o=1 only in cycle 4.
//    - ready_o=0 in cycles 1-3.
//  2 Back-to-back:
//    - Stimulus: 4'b1011 then 4'b0110, valid_i held high.
//    - Response: 8 consecutive valid bits 1,0,1,1,0,1,1,0; last_o in cycles 4 and 8.
//    - No x_valid_o gap.
//  3 Loopback:
//    - Stimulus: x_o fed to a 4-bit left-shifting deserializer (shift in at LSB), enabled by x_valid_o.
//    - Response: after each last_o bit, the deserializer register equals the word sent,
//      for 4'h0, 4'hF, 4'hA, 4'h5 and 100 random words.
//  4 Handshake stall and data hold:
//    - Stimulus: valid_i=1 while busy (cycles 1-2), with data_i changed mid-word.
//    - Response: no acceptance before the last-bit cycle; the transmitted word is unchanged.
//    - Stimulus: valid_i=0 in IDLE.
//    - Response: x_valid_o stays 0, x_o stays 0.
//  5 Reset mid-word:
//    - Stimulus: assert reset during cycle 2 of 4'b1011.
//    - Response: x_o, x_valid_o, last_o and busy_o go to 0 immediately; ready_o=1 after release.
//    - A subsequent word 4'b0011 is sent correctly.
//  6 LSB-first (MSB_FIRST=0):
//    - Stimulus: data_i=4'b1011.
//    - Response: x_o=1,1,0,1; last_o in cycle 4.

Source files
------------

// File: rtl/piso_serializer_if.sv
// Parallel word handshake into the serializer: word, valid strobe, ready back.
interface piso_serializer_if #(
  parameter int unsigned WIDTH = 4
);
  logic [WIDTH-1:0] data_i;
  logic             valid_i;
  logic             ready_o;

  modport master (output data_i, output valid_i, input ready_o);
  modport slave  (input data_i, input valid_i, output ready_o);
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a
// valid/ready handshake and sends it one bit per clk with a bit-valid strobe
// and a last-bit marker. Back-to-back words are sent with no idle bubble.
module piso_serializer #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  piso_serializer_if.slave   in_if,
  output logic               x_o,
  output logic               x_valid_o,
  output logic               last_o,
  output logic               busy_o
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic [WIDTH-1:0] sreg_shifted;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state == SHIFT) && (cnt == CW'(WIDTH - 1));

  // ready comes from state/cnt only so it never loops back through valid_i
  assign in_if.ready_o = (state == IDLE) || last_bit;
  assign accept        = in_if.valid_i && in_if.ready_o;

  // Move one bit toward the output end, filling the vacated position with 0
  assign sreg_shifted = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0}
                                  : {1'b0, sreg[WIDTH-1:1]};

  // All outputs decode directly from registers; sreg is zero whenever idle,
  // so x_o is 0 outside valid bits without extra gating
  assign x_o       = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];
  assign x_valid_o = (state == SHIFT);
  assign busy_o    = (state == SHIFT);
  assign last_o    = last_bit;

  // State, counter and shift register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
      sreg  <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      sreg  <= sreg_nxt;
    end
  end

  // Next-state: load on acceptance, otherwise shift until the last bit
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = SHIFT;
          cnt_nxt   = '0;
          sreg_nxt  = in_if.data_i;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          cnt_nxt = '0;
          if (accept) begin
            sreg_nxt = in_if.data_i;
          end else begin
            state_nxt = IDLE;
            sreg_nxt  = '0;
          end
        end else begin
          cnt_nxt  = cnt + CW'(1);
          sreg_nxt = sreg_shifted;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        sreg_nxt  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: an MSB-first and an LSB-first instance checked
// against a queue-of-expected-bits model plus a left-shifting deserializer.
module tb_piso_serializer;

  localparam int unsigned W = 4;

  typedef struct {
    logic b;
    logic l;
  } bit_t;

  logic clk;
  logic reset;
  logic x1, xv1, last1, busy1;
  logic x2, xv2, last2, busy2;

  int compares = 0;
  int errors   = 0;
  int accepted1 = 0;

  bit_t           q1[$];
  bit_t           q2[$];
  logic [W-1:0]   sent1[$];
  logic [W-1:0]   des;

  piso_serializer_if #(.WIDTH(W)) if1 ();
  piso_serializer_if #(.WIDTH(W)) if2 ();

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
    .clk       (clk),
    .reset     (reset),
    .in_if     (if1),
    .x_o       (x1),
    .x_valid_o (xv1),
    .last_o    (last1),
    .busy_o    (busy1)
  );

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
    .clk       (clk),
    .reset     (reset),
    .in_if     (if2),
    .x_o       (x2),
    .x_valid_o (xv2),
    .last_o    (last2),
    .busy_o    (busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    compares++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    logic ev1, ex1, el1, ev2, ex2, el2;
    ev1 = (q1.size() > 0);
    ex1 = ev1 ? q1[0].b : 1'b0;
    el1 = ev1 ? q1[0].l : 1'b0;
    ev2 = (q2.size() > 0);
    ex2 = ev2 ? q2[0].b : 1'b0;
    el2 = ev2 ? q2[0].l : 1'b0;
    chk("msb_x",      W'(x1),    W'(ex1));
    chk("msb_xvalid", W'(xv1),   W'(ev1));
    chk("msb_last",   W'(last1), W'(el1));
    chk("msb_busy",   W'(busy1), W'(ev1));
    chk("lsb_x",      W'(x2),    W'(ex2));
    chk("lsb_xvalid", W'(xv2),   W'(ev2));
    chk("lsb_last",   W'(last2), W'(el2));
    chk("lsb_busy",   W'(busy2), W'(ev2));
  endtask

  // One clock cycle: drive inputs, check ready, advance model at the edge,
  // then check the serial outputs and the loopback deserializer.
  task automatic cycle(input logic v1, input logic [W-1:0] d1,
                       input logic v2, input logic [W-1:0] d2);
    logic r1, r2;
    if1.valid_i = v1;
    if1.data_i  = d1;
    if2.valid_i = v2;
    if2.data_i  = d2;
    // one bit or less left to send means the next word may be taken now
    r1 = (q1.size() <= 1);
    r2 = (q2.size() <= 1);
    #1;
    chk("msb_ready", W'(if1.ready_o), W'(r1));
    chk("lsb_ready", W'(if2.ready_o), W'(r2));
    @(posedge clk);
    if (q1.size() > 0) void'(q1.pop_front());
    if (q2.size() > 0) void'(q2.pop_front());
    if (v1 && r1) begin
      for (int i = 0; i < int'(W); i++) q1.push_back('{b: d1[W-1-i], l: (i == int'(W) - 1)});
      sent1.push_back(d1);
      accepted1++;
    end
    if (v2 && r2) begin
      for (int i = 0; i < int'(W); i++) q2.push_back('{b: d2[i], l: (i == int'(W) - 1)});
    end
    #1;
    chk_outputs();
    if (xv1 === 1'b1) begin
      des = {des[W-2:0], x1};
      if (last1 === 1'b1) begin
        if (sent1.size() > 0) chk("loopback", des, sent1.pop_front());
        else chk("loopback_extra_word", 4'h1, 4'h0);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, 4'h0);
  endtask

  initial begin
    logic [W-1:0] w;
    logic         v;
    int           guard;
    reset = 1'b1;
    des   = '0;
    if1.valid_i = 1'b1;
    if1.data_i  = 4'hD;
    if2.valid_i = 1'b1;
    if2.data_i  = 4'hD;
    // handshake held during reset must be ignored
    repeat (2) @(posedge clk);
    #1;
    chk_outputs();
    #1;
    reset = 1'b0;
    idle(2);

    // Single word, MSB-first and LSB-first
    cycle(1'b1, 4'b1011, 1'b1, 4'b1011);
    idle(5);

    // Back-to-back with valid held high
    cycle(1'b1, 4'b1011, 1'b1, 4'b1011);
    cycle(1'b1, 4'b0110, 1'b1, 4'b0110);
    cycle(1'b1, 4'b0110, 1'b1, 4'b0110);
    cycle(1'b1, 4'b0110, 1'b1, 4'b0110);
    cycle(1'b1, 4'b0110, 1'b1, 4'b0110);
    idle(5);

    // Stall while busy with data changing mid-word, then idle with valid low
    cycle(1'b1, 4'b1001, 1'b0, 4'h0);
    cycle(1'b1, 4'b0110, 1'b0, 4'h0);
    cycle(1'b1, 4'b1111, 1'b0, 4'h0);
    cycle(1'b0, 4'b0000, 1'b0, 4'h0);
    cycle(1'b0, 4'b0101, 1'b0, 4'h0);
    idle(4);

    // Corner words back-to-back
    cycle(1'b1, 4'h0, 1'b0, 4'h0);
    idle(3);
    cycle(1'b1, 4'hF, 1'b0, 4'h0);
    idle(3);
    cycle(1'b1, 4'hA, 1'b0, 4'h0);
    idle(3);
    cycle(1'b1, 4'h5, 1'b0, 4'h0);
    idle(5);

    // Reset in cycle 2 of a word aborts it immediately
    cycle(1'b1, 4'b1011, 1'b1, 4'b1011);
    idle(1);
    reset = 1'b1;
    #1;
    q1.delete();
    q2.delete();
    sent1.delete();
    des = '0;
    chk_outputs();
    @(posedge clk);
    #1;
    chk_outputs();
    reset = 1'b0;
    cycle(1'b1, 4'b0011, 1'b1, 4'b0011);
    idle(5);

    // 100 random words with random valid gaps
    accepted1 = 0;
    guard = 0;
    while (accepted1 < 100 && guard < 2000) begin
      v = ($urandom_range(0, 3) != 0);
      w = W'($urandom);
      cycle(v, w, v, W'($urandom));
      guard++;
    end
    if (guard >= 2000) chk("random_budget", W'(accepted1 >= 100), W'(1));
    idle(6);
    chk("words_drained", W'(sent1.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compares, errors);
    $finish;
  end

endmodule
